// File: rtl/can_bit_sync_ctrl.sv
// CAN bit synchroniser: bus-idle detection, hard-sync requests and SJW-clamped soft resync.
// Optional RX glitch filter enabled by defining CAN_SYNC_GLITCH_FILTER_EN.
module can_bit_sync_ctrl #(
  parameter int IDLE_BITS = 11,
  parameter int TQ_W      = 6,
  parameter int SJW_W     = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   rx_in,
  input  logic                   sample_tick,
  input  logic [TQ_W-1:0]        tq_index,
  input  logic [TQ_W-1:0]        seg1_end,
  input  logic [TQ_W-1:0]        nbt,
  input  logic [SJW_W-1:0]       sjw,
  input  logic                   in_frame,
  output logic                   bus_idle,
  output logic                   hard_sync_req,
  output logic                   resync_req,
  output logic signed [TQ_W:0]   phase_err,
  output logic [7:0]             idle_count
);

  localparam int       PW       = TQ_W + 1;
  localparam bit [7:0] IDLE_MAX = 8'(IDLE_BITS);

  logic                 rx_f;
  logic                 rx_prev_reg;
  logic                 edge_armed_reg;
  logic                 bus_idle_reg;
  logic                 hard_sync_reg;
  logic                 resync_reg;
  logic signed [PW-1:0] phase_err_reg;
  logic [7:0]           idle_count_reg;

`ifdef CAN_SYNC_GLITCH_FILTER_EN
  // Three-stage shift; the 2-of-3 vote rejects single-cycle dominant glitches.
  logic [2:0] rx_sh_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sh_reg <= 3'b111;
    end else if (!enable) begin
      rx_sh_reg <= 3'b111;
    end else begin
      rx_sh_reg <= {rx_sh_reg[1:0], rx_in};
    end
  end

  assign rx_f = (rx_sh_reg[0] & rx_sh_reg[1]) |
                (rx_sh_reg[0] & rx_sh_reg[2]) |
                (rx_sh_reg[1] & rx_sh_reg[2]);
`else
  assign rx_f = rx_in;
`endif

  logic fedge;
  logic edge_accept;
  logic hs_hit;
  logic rs_hit;
  logic rs_fire;

  assign fedge       = rx_prev_reg & ~rx_f;
  assign edge_accept = fedge & edge_armed_reg;
  assign hs_hit      = edge_accept & (bus_idle_reg | ~in_frame);
  assign rs_hit      = edge_accept & in_frame & ~bus_idle_reg;
  // An edge in the sync segment is already in phase: it disarms but raises nothing.
  assign rs_fire     = rs_hit & (tq_index != '0);

  logic signed [PW-1:0] tq_s;
  logic signed [PW-1:0] nbt_s;
  logic signed [PW-1:0] sjw_s;
  logic signed [PW-1:0] e_raw;
  logic signed [PW-1:0] e_clamped;

  assign tq_s  = $signed({1'b0, tq_index});
  assign nbt_s = $signed({1'b0, nbt});
  assign sjw_s = $signed(PW'(sjw));

  always_comb begin
    e_raw = tq_s;
    if (tq_index > seg1_end) begin
      e_raw = tq_s - nbt_s;
    end
    e_clamped = e_raw;
    if (e_raw > sjw_s) begin
      e_clamped = sjw_s;
    end else if (e_raw < -sjw_s) begin
      e_clamped = -sjw_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev_reg    <= 1'b1;
      edge_armed_reg <= 1'b1;
      bus_idle_reg   <= 1'b0;
      hard_sync_reg  <= 1'b0;
      resync_reg     <= 1'b0;
      phase_err_reg  <= '0;
      idle_count_reg <= '0;
    end else if (!enable) begin
      rx_prev_reg    <= 1'b1;
      edge_armed_reg <= 1'b1;
      bus_idle_reg   <= 1'b0;
      hard_sync_reg  <= 1'b0;
      resync_reg     <= 1'b0;
      phase_err_reg  <= '0;
      idle_count_reg <= '0;
    end else begin
      rx_prev_reg   <= rx_f;
      hard_sync_reg <= hs_hit;
      resync_reg    <= rs_fire;
      if (rs_fire) begin
        phase_err_reg <= e_clamped;
      end

      if (edge_accept) begin
        edge_armed_reg <= 1'b0;
      end else if (sample_tick && rx_f) begin
        edge_armed_reg <= 1'b1;
      end

      // A hard sync restarts idle detection regardless of a coincident tick.
      if (hs_hit) begin
        idle_count_reg <= '0;
        bus_idle_reg   <= 1'b0;
      end else if (sample_tick) begin
        if (rx_f) begin
          if (idle_count_reg < IDLE_MAX) begin
            idle_count_reg <= idle_count_reg + 8'd1;
          end
          if (idle_count_reg == IDLE_MAX - 8'd1) begin
            bus_idle_reg <= 1'b1;
          end
        end else begin
          idle_count_reg <= '0;
          bus_idle_reg   <= 1'b0;
        end
      end
    end
  end

  assign bus_idle      = bus_idle_reg;
  assign hard_sync_req = hard_sync_reg;
  assign resync_req    = resync_reg;
  assign phase_err     = phase_err_reg;
  assign idle_count    = idle_count_reg;

endmodule

// File: tb/tb_can_bit_sync_ctrl.sv
// Self-checking bench for can_bit_sync_ctrl: directed scenarios plus random traffic
// compared every cycle against an event-level behavioural model.
module tb_can_bit_sync_ctrl;

  localparam int IDLE_BITS = 11;
  localparam int TQ_W      = 6;
  localparam int SJW_W     = 3;
`ifdef CAN_SYNC_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic                 rx_in;
  logic                 sample_tick;
  logic [TQ_W-1:0]      tq_index;
  logic [TQ_W-1:0]      seg1_end;
  logic [TQ_W-1:0]      nbt;
  logic [SJW_W-1:0]     sjw;
  logic                 in_frame;
  logic                 bus_idle;
  logic                 hard_sync_req;
  logic                 resync_req;
  logic signed [TQ_W:0] phase_err;
  logic [7:0]           idle_count;

  can_bit_sync_ctrl #(
    .IDLE_BITS(IDLE_BITS), .TQ_W(TQ_W), .SJW_W(SJW_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .rx_in(rx_in),
    .sample_tick(sample_tick), .tq_index(tq_index), .seg1_end(seg1_end),
    .nbt(nbt), .sjw(sjw), .in_frame(in_frame), .bus_idle(bus_idle),
    .hard_sync_req(hard_sync_req), .resync_req(resync_req),
    .phase_err(phase_err), .idle_count(idle_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_rx_prev, m_armed, m_idle, m_bus_idle, m_hs, m_rs, m_pe;
  int m_h[3];

  task automatic m_clear();
    m_rx_prev = 1; m_armed = 1; m_idle = 0; m_bus_idle = 0;
    m_hs = 0; m_rs = 0; m_pe = 0;
    m_h[0] = 1; m_h[1] = 1; m_h[2] = 1;
  endtask

  // Predicts the registered outputs after the coming clock edge.
  task automatic model_eval();
    int rxf, e, s;
    bit edge_seen;
    if (!reset_n || !enable) begin
      m_clear();
      return;
    end
`ifdef CAN_SYNC_GLITCH_FILTER_EN
    rxf = ((m_h[0] + m_h[1] + m_h[2]) >= 2) ? 1 : 0;
    m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = int'(rx_in);
`else
    rxf = int'(rx_in);
`endif
    edge_seen = (m_rx_prev == 1) && (rxf == 0);
    m_hs = 0;
    m_rs = 0;
    if (edge_seen && m_armed == 1) begin
      m_armed = 0;
      if (m_bus_idle == 1 || !in_frame) begin
        m_hs = 1; m_bus_idle = 0; m_idle = 0;
      end else if (tq_index != 0) begin
        s = int'(sjw);
        if (int'(tq_index) <= int'(seg1_end)) e = int'(tq_index);
        else e = int'(tq_index) - int'(nbt);
        if (e > s) e = s;
        if (e < -s) e = -s;
        m_rs = 1; m_pe = e;
      end
    end else if (sample_tick && rxf == 1) begin
      m_armed = 1;
    end
    if (sample_tick && m_hs == 0) begin
      if (rxf == 1) begin
        if (m_idle < IDLE_BITS) m_idle++;
        if (m_idle == IDLE_BITS) m_bus_idle = 1;
      end else begin
        m_idle = 0; m_bus_idle = 0;
      end
    end
    m_rx_prev = rxf;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cmp_all();
    chk("bus_idle", bus_idle, m_bus_idle);
    chk("hard_sync_req", hard_sync_req, m_hs);
    chk("resync_req", resync_req, m_rs);
    chk("phase_err", phase_err, m_pe);
    chk("idle_count", idle_count, m_idle);
  endtask

  task automatic step();
    model_eval();
    @(posedge clock);
    #1;
    cmp_all();
  endtask

  task automatic arm();
    rx_in = 1'b1;
    repeat (3) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
  endtask

  task automatic edge_at(input int tq);
    tq_index = TQ_W'(tq);
    rx_in = 1'b0;
    repeat (LAT) step();
  endtask

  initial begin
    int seg_mode;
    m_clear();
    reset_n = 1'b0; enable = 1'b0; rx_in = 1'b1; sample_tick = 1'b0;
    tq_index = '0; seg1_end = 6'd6; nbt = 6'd10; sjw = 3'd2; in_frame = 1'b0;
    repeat (3) step();
    chk("reset_idle_count", idle_count, 0);
    chk("reset_bus_idle", bus_idle, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) step();

    // Idle detection over IDLE_BITS recessive sample points
    for (int i = 1; i <= IDLE_BITS; i++) begin
      sample_tick = 1'b1; step();
      sample_tick = 1'b0;
      chk("idle_ramp", idle_count, i);
      chk("idle_flag", bus_idle, (i == IDLE_BITS) ? 1 : 0);
      step();
    end
    repeat (2) begin sample_tick = 1'b1; step(); sample_tick = 1'b0; step(); end
    chk("idle_saturate", idle_count, IDLE_BITS);

    // Hard sync from idle
    edge_at(3);
    chk("hs_pulse", hard_sync_req, 1);
    chk("hs_bus_idle", bus_idle, 0);
    chk("hs_idle_count", idle_count, 0);
    chk("hs_no_resync", resync_req, 0);
    step();
    chk("hs_one_cycle", hard_sync_req, 0);

    // Late and early resync
    in_frame = 1'b1;
    arm();
    edge_at(5);
    chk("late_resync", resync_req, 1);
    chk("late_phase", phase_err, 2);
    step();
    chk("late_one_cycle", resync_req, 0);
    arm();
    edge_at(9);
    chk("early_resync", resync_req, 1);
    chk("early_phase", phase_err, -1);
    step();

    // Edge in sync segment: consumed silently, phase_err holds
    arm();
    edge_at(0);
    chk("tq0_no_resync", resync_req, 0);
    chk("tq0_phase_hold", phase_err, -1);
    step();

    // Second edge without a recessive sample point is ignored
    arm();
    edge_at(5);
    chk("first_edge", resync_req, 1);
    step();
    rx_in = 1'b1;
    repeat (3) step();
    edge_at(3);
    chk("second_edge_ignored", resync_req, 0);
    chk("second_edge_no_hs", hard_sync_req, 0);
    step();

    // Edge coinciding with sample_tick
    arm();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    tq_index = 6'd4;
    rx_in = 1'b0;
    repeat (LAT - 1) step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("coincide_resync", resync_req, 1);
    chk("coincide_idle_clear", idle_count, 0);
    step();

    // Enable dropped with an edge pending
    arm();
    tq_index = 6'd5; rx_in = 1'b0; enable = 1'b0;
    step();
    chk("dis_resync", resync_req, 0);
    chk("dis_idle_count", idle_count, 0);
    chk("dis_phase", phase_err, 0);
    enable = 1'b1; rx_in = 1'b1;
    repeat (3) step();

`ifdef CAN_SYNC_GLITCH_FILTER_EN
    arm();
    tq_index = 6'd5; rx_in = 1'b0; step(); rx_in = 1'b1;
    repeat (4) begin step(); chk("glitch_no_pulse", resync_req, 0); end
    edge_at(5);
    chk("filter_3cyc", resync_req, 1);
    step();
`endif

    // Random traffic checked every cycle against the model
    for (int seg = 0; seg < 20; seg++) begin
      nbt      = TQ_W'($urandom_range(3, 12));
      seg1_end = TQ_W'($urandom_range(1, int'(nbt) - 1));
      sjw      = SJW_W'($urandom_range(1, 7));
      seg_mode = $urandom_range(0, 1);
      tq_index = '0;
      rx_in    = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tq_index    = (int'(tq_index) + 1 >= int'(nbt)) ? '0 : tq_index + 1'b1;
        sample_tick = (int'(tq_index) == int'(seg1_end) + 1);
        if ($urandom_range(0, (seg_mode == 0) ? 5 : 199) == 0) rx_in = ~rx_in;
        if ($urandom_range(0, 49) == 0) in_frame = ~in_frame;
        enable = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    sample_tick = 1'b0;
    enable = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
